seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan -- eight-digit multiplexed hex seven-segment display driver.
//
// A prescaler divides clk by SCAN_DIV; each prescaler wrap advances the digit
// index 0..7. One digit is shown at a time. Data written with 'load' is held
// in a shadow register. It is copied to the display registers only at a
// frame boundary (digit 7 -> 0), so a frame never mixes old and new data.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit is displayed (1 .. 2^20)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   data     eight hex digits, digit k = data[4k+3:4k], digit 0 rightmost
//   dp       per-digit decimal point, active-high
//   load     single-cycle strobe capturing data/dp into the shadow registers
//   seg      segment drive, active-low, seg[7]=dp, seg[6:0]=g..a
//   en       digit enable, active-low, exactly one bit low
//   frame    one-cycle pulse after each 7->0 digit wrap
//   pending  shadow holds data not yet transferred to the display
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, digit k (k>=1) is blanked while display nibbles k..7 are
//   all zero. The decimal point still follows dp. Digit 0 is never blanked.
// -----------------------------------------------------------------------------
module seg_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [7:0]  en,
  output logic        frame,
  output logic        pending
);

  // A one-bit counter is kept for SCAN_DIV=1 so the width never goes to zero.
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;
  logic [31:0]   disp_data;
  logic [7:0]    disp_dp;
  logic [31:0]   disp_data_next;
  logic [7:0]    disp_dp_next;
  logic          tick;
  logic          wrap;
  logic          xfer;

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Full segment byte for digit k of a display word, including the dp bit.
  function automatic logic [7:0] digit_seg(input logic [31:0] d,
                                           input logic [7:0]  p,
                                           input logic [2:0]  k);
    logic [6:0] low;
    low = decode(d[{k, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    // Nibbles k..7 all zero means this digit is a leading zero.
    if ((k != 3'd0) && ((d >> {k, 2'b00}) == 32'd0)) begin
      low = 7'h7F;
    end
`endif
    return {~p[k], low};
  endfunction

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == 3'd7);
  assign xfer = wrap && pending;

  // Next digit index and display contents. seg/en are registered from these
  // so they change on the same edge as idx and always describe one digit.
  always_comb begin
    idx_next       = idx;
    disp_data_next = disp_data;
    disp_dp_next   = disp_dp;
    if (tick) begin
      idx_next = idx + 3'd1;
    end
    if (xfer) begin
      disp_data_next = shadow_data;
      disp_dp_next   = shadow_dp;
    end
  end

  // Scan state, display/shadow registers and registered outputs.
  // A load on a transfer edge still sets pending: the old shadow has just
  // moved to the display and the new data now waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 3'd0;
      shadow_data <= 32'd0;
      shadow_dp   <= 8'd0;
      disp_data   <= 32'd0;
      disp_dp     <= 8'd0;
      pending     <= 1'b0;
      frame       <= 1'b0;
      en          <= 8'hFE;
      seg         <= 8'hC0;
    end else begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      idx       <= idx_next;
      disp_data <= disp_data_next;
      disp_dp   <= disp_dp_next;
      frame     <= wrap;
      en        <= ~(8'd1 << idx_next);
      seg       <= digit_seg(disp_data_next, disp_dp_next, idx_next);
      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp;
        pending     <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
